seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan.sv | 108 ++++++++++
 tb/tb_seven_seg_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit multiplexed seven-segment scanner
// Frame-latched BCD digits, optional leading-zero blanking, registered active-low outputs.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] sec_out0,
  input  logic [3:0] sec_out1,
  input  logic [3:0] sec_out2,
  input  logic [3:0] sec_out3,
  input  logic       LZ_BLANK,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [3:0]    sh0, sh1, sh2, sh3;
  logic          tick;
  logic [3:0]    digit;
  logic          z1, z2, z3;
  logic          lz_kill;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  assign tick = (div_cnt == DIV_LAST);
  assign DP   = 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      sh0     <= 4'hF;
      sh1     <= 4'hF;
      sh2     <= 4'hF;
      sh3     <= 4'hF;
      AN      <= 4'hF;
      SEG     <= 7'h7F;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      if (tick) begin
        idx <= idx + 2'd1;
        // whole frame captured at once so digits never tear mid-scan
        if (idx == 2'd3) begin
          sh0 <= sec_out0;
          sh1 <= sec_out1;
          sh2 <= sec_out2;
          sh3 <= sec_out3;
        end
      end
      AN  <= an_next;
      SEG <= seg_next;
    end
  end

  always_comb begin
    digit   = sh0;
    an_next = 4'b1110;
    case (idx)
      2'd0: begin digit = sh0; an_next = 4'b1110; end
      2'd1: begin digit = sh1; an_next = 4'b1101; end
      2'd2: begin digit = sh2; an_next = 4'b1011; end
      2'd3: begin digit = sh3; an_next = 4'b0111; end
      default: ;
    endcase
  end

  // a blank code (15) counts as a leading zero as well
  always_comb begin
    z1 = (sh1 == 4'd0) || (sh1 == 4'hF);
    z2 = (sh2 == 4'd0) || (sh2 == 4'hF);
    z3 = (sh3 == 4'd0) || (sh3 == 4'hF);
    lz_kill = 1'b0;
    case (idx)
      2'd1: lz_kill = z3 & z2 & z1;
      2'd2: lz_kill = z3 & z2;
      2'd3: lz_kill = z3;
      default: lz_kill = 1'b0;
    endcase
    lz_kill = lz_kill & LZ_BLANK;
  end

  always_comb begin
    seg_next = 7'b1111111;
    if (!lz_kill) begin
      case (digit)
        4'd0: seg_next = 7'b1000000;
        4'd1: seg_next = 7'b1111001;
        4'd2: seg_next = 7'b0100100;
        4'd3: seg_next = 7'b0110000;
        4'd4: seg_next = 7'b0011001;
        4'd5: seg_next = 7'b0010010;
        4'd6: seg_next = 7'b0000010;
        4'd7: seg_next = 7'b1111000;
        4'd8: seg_next = 7'b0000000;
        4'd9: seg_next = 7'b0010000;
        4'hF: seg_next = 7'b1111111;
        default: seg_next = 7'b0111111;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan
// Frame-level reference model plus directed literal checks and randomized traffic.
module tb_seven_seg_scan;

  localparam int R = 4;
  localparam int FRAME = 4 * R;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] sec_out0 = 4'd4, sec_out1 = 4'd3, sec_out2 = 4'd2, sec_out3 = 4'd1;
  logic       LZ_BLANK = 1'b0;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;

  seven_seg_scan #(.REFRESH_DIV(R)) dut (
    .CLK(CLK), .RESET(RESET),
    .sec_out0(sec_out0), .sec_out1(sec_out1), .sec_out2(sec_out2), .sec_out3(sec_out3),
    .LZ_BLANK(LZ_BLANK), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_tab(input int code);
    case (code)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  15: return 7'b1111111;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] an_lit(input int i);
    case (i)
      0: return 4'b1110;  1: return 4'b1101;
      2: return 4'b1011;  default: return 4'b0111;
    endcase
  endfunction

  // reference model: mk = clean edges since last reset, frame contents in msh
  int         mk = 0;
  bit         mvalid = 0;
  int         m_idx;
  logic [3:0] msh [4];
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;

  function automatic logic [6:0] model_seg(input int i, input logic lz);
    int msd = -1;
    for (int d = 3; d >= 0; d--)
      if (msd < 0 && msh[d] != 4'd0 && msh[d] != 4'hF) msd = d;
    if (lz && i > 0 && i > msd) return 7'h7F;
    return seg_tab(int'(msh[i]));
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      mk = 0;
      for (int d = 0; d < 4; d++) msh[d] = 4'hF;
      m_an = 4'hF;
      m_seg = 7'h7F;
      mvalid = 1;
    end else if (mvalid) begin
      m_idx = (mk / R) % 4;
      m_an = an_lit(m_idx);
      m_seg = model_seg(m_idx, LZ_BLANK);
      mk++;
      if (mk % FRAME == 0) begin
        msh[0] = sec_out0; msh[1] = sec_out1; msh[2] = sec_out2; msh[3] = sec_out3;
      end
    end
  end

  always @(negedge CLK) begin
    if (mvalid) begin
      chk("model_an", {3'b0, AN}, {3'b0, m_an});
      chk("model_seg", SEG, m_seg);
      chk("dp", {6'b0, DP}, 7'd1);
    end
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    chk("reset_an", {3'b0, AN}, 7'h0F);
    chk("reset_seg", SEG, 7'h7F);
    RESET = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] d3, d2, d1, d0, input logic lz,
                           input logic [6:0] e0, e1, e2, e3, input string nm);
    logic [6:0] e [4];
    int guard = 0;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    sec_out3 = d3; sec_out2 = d2; sec_out1 = d1; sec_out0 = d0; LZ_BLANK = lz;
    do begin
      step();
      guard++;
    end while (mk % FRAME != 0 && guard < 3 * FRAME);
    if (guard >= 3 * FRAME) chk({nm, "_timeout"}, 7'd1, 7'd0);
    for (int j = 0; j < FRAME; j++) begin
      step();
      chk({nm, "_an"}, {3'b0, AN}, {3'b0, an_lit(j / R)});
      chk({nm, "_seg"}, SEG, e[j / R]);
    end
  endtask

  initial begin
    do_reset();
    // first frame blank, AN walks digits 4 clocks each
    for (int j = 1; j <= 16; j++) begin
      step();
      chk("f1_an", {3'b0, AN}, {3'b0, an_lit((j - 1) / 4)});
      chk("f1_seg", SEG, 7'b1111111);
    end
    // second frame shows 1234
    for (int j = 17; j <= 32; j++) begin
      step();
      case ((j - 17) / 4)
        0: chk("f2_d0", SEG, 7'b0011001);
        1: chk("f2_d1", SEG, 7'b0110000);
        2: chk("f2_d2", SEG, 7'b0100100);
        default: chk("f2_d3", SEG, 7'b1111001);
      endcase
    end
    // inputs change mid-frame; current frame keeps old digits
    for (int j = 33; j <= 53; j++) begin
      step();
      if (j == 37) begin
        sec_out3 = 4'd5; sec_out2 = 4'd6; sec_out1 = 4'd7; sec_out0 = 4'd8;
      end
      if (j == 40) chk("mid_d1_old", SEG, 7'b0110000);
      if (j == 44) chk("mid_d2_old", SEG, 7'b0100100);
      if (j == 48) chk("mid_d3_old", SEG, 7'b1111001);
      if (j == 49) chk("new_d0", SEG, 7'b0000000);
      if (j == 53) chk("new_d1", SEG, 7'b1111000);
    end

    run_frame(4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 7'b1111000, 7'h7F, 7'h7F, 7'h7F, "lz_on");
    run_frame(4'd0, 4'd0, 4'd0, 4'd7, 1'b0, 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000, "lz_off");
    run_frame(4'd15, 4'd15, 4'd15, 4'd12, 1'b0, 7'b0111111, 7'h7F, 7'h7F, 7'h7F, "dash");
    run_frame(4'd0, 4'd15, 4'd0, 4'd0, 1'b1, 7'b1000000, 7'h7F, 7'h7F, 7'h7F, "lz_all0");
    run_frame(4'd0, 4'd3, 4'd0, 4'd0, 1'b1, 7'b1000000, 7'b1000000, 7'b0110000, 7'h7F, "lz_inner");
    for (int c = 0; c < 16; c += 4)
      run_frame(4'(c + 3), 4'(c + 2), 4'(c + 1), 4'(c), 1'b0,
                seg_tab(c), seg_tab(c + 1), seg_tab(c + 2), seg_tab(c + 3), "codes");

    // reset pulse while idx=2
    begin
      int guard = 0;
      while (!(mk % FRAME == 2 * R + 1) && guard < 2 * FRAME) begin
        step();
        guard++;
      end
      if (guard >= 2 * FRAME) chk("idx2_timeout", 7'd1, 7'd0);
    end
    RESET = 1'b1;
    step();
    chk("midrst_an", {3'b0, AN}, 7'h0F);
    chk("midrst_seg", SEG, 7'h7F);
    RESET = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step();
      chk("rst_f1_an", {3'b0, AN}, {3'b0, an_lit((j - 1) / 4)});
      chk("rst_f1_seg", SEG, 7'b1111111);
    end

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      if (RESET) RESET = 1'b0;
      else if ($urandom_range(299) == 0) RESET = 1'b1;
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: sec_out0 = 4'($urandom_range(15));
          1: sec_out1 = 4'($urandom_range(15));
          2: sec_out2 = 4'($urandom_range(15));
          default: sec_out3 = 4'($urandom_range(15));
        endcase
      end
      if ($urandom_range(3) == 0) sec_out3 = 4'd0;
      if ($urandom_range(49) == 0) LZ_BLANK = ~LZ_BLANK;
      step();
    end
    RESET = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
